// File: rtl/shift_register_universal_if.sv
// Bus bundle for shift_register_universal: control, serial/parallel data and status.
// master drives control and data; slave is the register itself.
interface shift_register_universal_if #(
   parameter int WIDTH = 4
) ();
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             en;
   logic [1:0]       mode;
   logic             s_in_r;
   logic             s_in_l;
   logic [WIDTH-1:0] p_in;
   logic             rot;
   logic [WIDTH-1:0] q;
   logic             s_out_r;
   logic             s_out_l;
   logic [CNT_W-1:0] shift_cnt;
   logic             word_done;

   modport master (
      output en, mode, s_in_r, s_in_l, p_in, rot,
      input  q, s_out_r, s_out_l, shift_cnt, word_done
   );

   modport slave (
      input  en, mode, s_in_r, s_in_l, p_in, rot,
      output q, s_out_r, s_out_l, shift_cnt, word_done
   );
endinterface

// File: rtl/shift_register_universal.sv
// Universal shift register: hold / shift right / shift left / parallel load, with a
// saturating shift counter and word-complete pulse. Define SHIFT_ROTATE_EN to enable rotation.
module shift_register_universal #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic                           clk,
   input  logic                           reset,
   shift_register_universal_if.slave      bus
);
   localparam int               CNT_W   = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_RIGHT = 2'b01,
      MODE_LEFT  = 2'b10,
      MODE_LOAD  = 2'b11
   } mode_e;

   logic [WIDTH-1:0] q_reg, q_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             done_reg, done_next;
   logic [WIDTH-1:0] right_val, left_val;
   logic             fill_r, fill_l;
   logic             shifting;

   // Bits entering at each end; with rotation they are the bits leaving the other end.
`ifdef SHIFT_ROTATE_EN
   assign fill_r = bus.rot ? q_reg[0]       : bus.s_in_r;
   assign fill_l = bus.rot ? q_reg[WIDTH-1] : bus.s_in_l;
`else
   logic unused_rot;
   assign unused_rot = bus.rot;
   assign fill_r     = bus.s_in_r;
   assign fill_l     = bus.s_in_l;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bits
         if (gi == WIDTH - 1) begin : g_right_msb
            assign right_val[gi] = fill_r;
         end else begin : g_right_mid
            assign right_val[gi] = q_reg[gi+1];
         end

         if (gi == 0) begin : g_left_lsb
            assign left_val[gi] = fill_l;
         end else begin : g_left_mid
            assign left_val[gi] = q_reg[gi-1];
         end
      end
   endgenerate

   always_comb begin
      q_next    = q_reg;
      cnt_next  = cnt_reg;
      done_next = 1'b0;
      shifting  = 1'b0;

      if (bus.en) begin
         case (mode_e'(bus.mode))
            MODE_RIGHT: begin
               q_next   = right_val;
               shifting = 1'b1;
            end
            MODE_LEFT: begin
               q_next   = left_val;
               shifting = 1'b1;
            end
            MODE_LOAD: begin
               q_next   = bus.p_in;
               cnt_next = '0;
            end
            default: ;
         endcase
      end

      // Pulse only on the WIDTH-1 -> WIDTH transition, so saturated shifts stay quiet.
      if (shifting) begin
         if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
         end
         done_next = (cnt_reg == CNT_MAX - 1'b1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_reg    <= RESET_VAL;
         cnt_reg  <= '0;
         done_reg <= 1'b0;
      end else begin
         q_reg    <= q_next;
         cnt_reg  <= cnt_next;
         done_reg <= done_next;
      end
   end

   assign bus.q         = q_reg;
   assign bus.s_out_r   = q_reg[0];
   assign bus.s_out_l   = q_reg[WIDTH-1];
   assign bus.shift_cnt = cnt_reg;
   assign bus.word_done = done_reg;
endmodule

// File: tb/tb_shift_register_universal.sv
// Scoreboard bench for shift_register_universal at WIDTH=4 and WIDTH=8.
// Expected state is pushed when a cycle is driven and popped after the clock edge.
module tb_shift_register_universal;
   typedef struct {
      logic [7:0] q;
      int         cnt;
      logic       done;
   } exp_t;

`ifdef SHIFT_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   exp_t m4, m8;
   exp_t sb[$];

   shift_register_universal_if #(.WIDTH(4)) b4 ();
   shift_register_universal_if #(.WIDTH(8)) b8 ();

   shift_register_universal #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (b4.slave)
   );

   shift_register_universal #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (b8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference behaviour written arithmetically over an 8-bit container.
   function automatic exp_t model(exp_t cur, int w, logic en, logic [1:0] mode,
                                  logic sr, logic sl, logic [7:0] p, logic rot);
      exp_t       n;
      logic [7:0] mask;
      logic [7:0] qv;
      logic       in_bit;
      n      = cur;
      n.done = 1'b0;
      mask   = 8'((16'd1 << w) - 16'd1);
      qv     = cur.q;
      if (!en) return n;
      if (mode == 2'b11) begin
         n.q   = p & mask;
         n.cnt = 0;
      end else if (mode != 2'b00) begin
         if (mode == 2'b01) begin
            in_bit = (rot && ROT_EN) ? qv[0] : sr;
            n.q    = ((qv >> 1) | (8'(in_bit) << (w - 1))) & mask;
         end else begin
            in_bit = (rot && ROT_EN) ? qv[w-1] : sl;
            n.q    = ((qv << 1) | 8'(in_bit)) & mask;
         end
         n.done = (cur.cnt == w - 1);
         n.cnt  = (cur.cnt < w) ? cur.cnt + 1 : w;
      end
      return n;
   endfunction

   function automatic logic [7:0] dut_q(int w);
      return (w == 4) ? {4'b0, b4.q} : b8.q;
   endfunction

   task automatic step(input int w, input logic en, input logic [1:0] mode, input logic sr,
                       input logic sl, input logic [7:0] p, input logic rot);
      exp_t       cur, nxt, got_exp;
      logic [7:0] cur_dq;
      int         dcnt;
      logic       ddone, dsr, dsl;
      cur = (w == 4) ? m4 : m8;
      b4.en = 1'b0; b8.en = 1'b0;
      if (w == 4) begin
         b4.en = en; b4.mode = mode; b4.s_in_r = sr; b4.s_in_l = sl; b4.p_in = p[3:0]; b4.rot = rot;
      end else begin
         b8.en = en; b8.mode = mode; b8.s_in_r = sr; b8.s_in_l = sl; b8.p_in = p; b8.rot = rot;
      end
      dsr = (w == 4) ? b4.s_out_r : b8.s_out_r;
      dsl = (w == 4) ? b4.s_out_l : b8.s_out_l;
      chk("s_out_r", 32'(dsr), 32'(cur.q[0]));
      chk("s_out_l", 32'(dsl), 32'(cur.q[w-1]));
      nxt = model(cur, w, en, mode, sr, sl, p, rot);
      sb.push_back(nxt);
      @(posedge clk);
      #1;
      got_exp = sb.pop_front();
      cur_dq  = dut_q(w);
      dcnt    = (w == 4) ? int'(b4.shift_cnt) : int'(b8.shift_cnt);
      ddone   = (w == 4) ? b4.word_done : b8.word_done;
      chk("q", 32'(cur_dq), 32'(got_exp.q));
      chk("shift_cnt", 32'(dcnt), 32'(got_exp.cnt));
      chk("word_done", 32'(ddone), 32'(got_exp.done));
      if (w == 4) m4 = got_exp; else m8 = got_exp;
      $display("w=%0d en=%b mode=%b sr=%b sl=%b rot=%b -> q=%h cnt=%0d done=%b",
               w, en, mode, sr, sl, rot, cur_dq, dcnt, ddone);
   endtask

   function automatic exp_t zero_state();
      exp_t z;
      z.q = 8'h00; z.cnt = 0; z.done = 1'b0;
      return z;
   endfunction

   initial begin
      logic [3:0] t2_bits;
      logic [3:0] t4_q [4];
      logic [3:0] t5_q [4];
      logic [7:0] a5;
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      b4.en = 1'b0; b4.mode = 2'b00; b4.s_in_r = 1'b0; b4.s_in_l = 1'b0; b4.p_in = '0; b4.rot = 1'b0;
      b8.en = 1'b0; b8.mode = 2'b00; b8.s_in_r = 1'b0; b8.s_in_l = 1'b0; b8.p_in = '0; b8.rot = 1'b0;
      m4 = zero_state();
      m8 = zero_state();

      #7;
      chk("rst_q4", 32'(b4.q), 32'h0);
      chk("rst_cnt4", 32'(b4.shift_cnt), 32'h0);
      chk("rst_q8", 32'(b8.q), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Asynchronous reset mid-run
      step(4, 1'b1, 2'b11, 1'b0, 1'b0, 8'h0B, 1'b0);
      step(4, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_q", 32'(b4.q), 32'h0);
      chk("async_rst_cnt", 32'(b4.shift_cnt), 32'h0);
      chk("async_rst_done", 32'(b4.word_done), 32'h0);
      m4 = zero_state();
      m8 = zero_state();
      @(negedge clk);
      reset = 1'b1;
      step(4, 1'b1, 2'b00, 1'b1, 1'b1, 8'h0F, 1'b0);
      step(4, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);

      // Load 1011 then shift right with zeros
      t2_bits = 4'b1011;
      step(4, 1'b1, 2'b11, 1'b0, 1'b0, 8'h0B, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("t2_serial", 32'(b4.s_out_r), 32'(t2_bits[i]));
         step(4, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
         chk("t2_cnt", 32'(b4.shift_cnt), 32'(i + 1));
         chk("t2_done", 32'(b4.word_done), 32'(i == 3));
      end
      chk("t2_q_end", 32'(b4.q), 32'h0);
      step(4, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t2_sat_cnt", 32'(b4.shift_cnt), 32'd4);
      chk("t2_sat_done", 32'(b4.word_done), 32'h0);

      // SISO latency: 4 enabled edges from s_in_r to s_out_r
      for (int k = 0; k < 4; k++) begin
         step(4, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
         chk("siso_rise", 32'(b4.s_out_r), 32'(k == 3));
      end
      for (int k = 0; k < 4; k++) begin
         step(4, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
         chk("siso_fall", 32'(b4.s_out_r), 32'(k != 3));
      end

      // Shift left filling with ones, then clock-enable low
      t4_q[0] = 4'h1; t4_q[1] = 4'h3; t4_q[2] = 4'h7; t4_q[3] = 4'hF;
      step(4, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(4, 1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
         chk("t4_q", 32'(b4.q), 32'(t4_q[i]));
         chk("t4_done", 32'(b4.word_done), 32'(i == 3));
      end
      for (int i = 0; i < 3; i++) begin
         step(4, 1'b0, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0);
         chk("t4_en_q", 32'(b4.q), 32'hF);
         chk("t4_en_cnt", 32'(b4.shift_cnt), 32'd4);
         chk("t4_en_done", 32'(b4.word_done), 32'h0);
      end

      // Rotate select
      if (ROT_EN) begin
         t5_q[0] = 4'h4; t5_q[1] = 4'h2; t5_q[2] = 4'h1; t5_q[3] = 4'h8;
      end else begin
         t5_q[0] = 4'h4; t5_q[1] = 4'h2; t5_q[2] = 4'h1; t5_q[3] = 4'h0;
      end
      step(4, 1'b1, 2'b11, 1'b0, 1'b0, 8'h08, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(4, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
         chk("t5_rot_q", 32'(b4.q), 32'(t5_q[i]));
      end

      // Direction change does not clear the counter
      step(4, 1'b1, 2'b11, 1'b0, 1'b0, 8'h06, 1'b0);
      step(4, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
      step(4, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
      step(4, 1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
      step(4, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("mix_done", 32'(b4.word_done), 32'h1);

      // WIDTH=8 serialiser
      a5 = 8'hA5;
      step(8, 1'b1, 2'b11, 1'b0, 1'b0, 8'hA5, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk("t6_serial", 32'(b8.s_out_r), 32'(a5[i]));
         step(8, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
         chk("t6_done", 32'(b8.word_done), 32'(i == 7));
      end
      chk("t6_q_end", 32'(b8.q), 32'hFF);
      step(8, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t6_sat_cnt", 32'(b8.shift_cnt), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
